blackjack_game_ctrl: RTL

//  Game sequencer for the blackjack datapath. Requests cards from the card source and deals the opening hands (P,D,P,D).

---
 rtl/blackjack_game_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/blackjack_game_ctrl.sv
// Blackjack game sequencer: deals P,D,P,D, runs the player turn and the dealer draw policy, then flags the result.
// Optional DEALER_HIT_SOFT17_EN: dealer also draws on soft 17 (H17); undefined = stand on all 17s (S17).
module blackjack_game_ctrl #(
    parameter int MAX_CARDS    = 5,
    parameter int DEALER_STAND = 17
) (
    input  logic       CLOCK_50,
    input  logic       resetb,
    input  logic       start,
    input  logic       hit_btn,
    input  logic       stand_btn,
    output logic       deal_req,
    input  logic       card_vld,
    input  logic [3:0] card_in,
    output logic [7:0] load_player,
    output logic [7:0] load_dealer,
    output logic [4:0] player_total,
    output logic [4:0] dealer_total,
    output logic       player_turn,
    output logic       player_win,
    output logic       dealer_win,
    output logic       push
);

    localparam logic [3:0] MAXC   = 4'(MAX_CARDS);
    localparam logic [6:0] DSTAND = 7'(DEALER_STAND);

    typedef enum logic [3:0] {
        IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2,
        PLAYER_TURN, PLAYER_DRAW, DEALER_TURN, DEALER_DRAW, RESULT
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] p_cnt, d_cnt;
    logic [6:0] p_raw, d_raw;
    logic       p_ace, d_ace;
    logic       start_q, hit_q, stand_q;

    function automatic logic [6:0] best_of(input logic [6:0] raw, input logic ace);
        best_of = (ace && (raw + 7'd10) <= 7'd21) ? raw + 7'd10 : raw;
    endfunction

    logic       start_rise, hit_rise, stand_rise;
    logic       rank_ok, card_ace, to_player, to_dealer, accept;
    logic [6:0] card_val, p_best, d_best, p_nxt_raw, p_nxt_best;
    logic       d_more;

    assign start_rise = start & ~start_q;
    assign hit_rise   = hit_btn & ~hit_q;
    assign stand_rise = stand_btn & ~stand_q;

    // Ranks outside 1..13 are never accepted, so the request stays up for a valid card.
    assign rank_ok   = (card_in >= 4'd1) && (card_in <= 4'd13);
    assign card_ace  = (card_in == 4'd1);
    assign card_val  = (card_in > 4'd10) ? 7'd10 : {3'b000, card_in};
    assign to_player = (state == DEAL_P1) || (state == DEAL_P2) || (state == PLAYER_DRAW);
    assign to_dealer = (state == DEAL_D1) || (state == DEAL_D2) || (state == DEALER_DRAW);
    assign accept    = (to_player || to_dealer) && card_vld && rank_ok;

    assign p_best     = best_of(p_raw, p_ace);
    assign d_best     = best_of(d_raw, d_ace);
    assign p_nxt_raw  = p_raw + card_val;
    assign p_nxt_best = best_of(p_nxt_raw, p_ace | card_ace);

`ifdef DEALER_HIT_SOFT17_EN
    logic d_soft;
    assign d_soft = d_ace && ((d_raw + 7'd10) <= 7'd21);
    assign d_more = (d_best < DSTAND) || ((d_best == 7'd17) && d_soft);
`else
    assign d_more = (d_best < DSTAND);
`endif

    always_ff @(posedge CLOCK_50 or negedge resetb) begin
        if (!resetb) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RESULT: if (start_rise) state_nxt = DEAL_P1;
            DEAL_P1:      if (accept) state_nxt = DEAL_D1;
            DEAL_D1:      if (accept) state_nxt = DEAL_P2;
            DEAL_P2:      if (accept) state_nxt = DEAL_D2;
            DEAL_D2:      if (accept) state_nxt = PLAYER_TURN;
            PLAYER_TURN: begin
                if (p_best == 7'd21 || p_cnt >= MAXC || stand_rise) state_nxt = DEALER_TURN;
                else if (hit_rise)                                  state_nxt = PLAYER_DRAW;
            end
            PLAYER_DRAW: begin
                if (accept) begin
                    if (p_nxt_best > 7'd21)          state_nxt = RESULT;
                    else if (p_cnt + 4'd1 == MAXC)   state_nxt = DEALER_TURN;
                    else                             state_nxt = PLAYER_TURN;
                end
            end
            DEALER_TURN:  state_nxt = (d_more && d_cnt < MAXC) ? DEALER_DRAW : RESULT;
            DEALER_DRAW:  if (accept) state_nxt = DEALER_TURN;
            default:      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetb) begin
        if (!resetb) begin
            {start_q, hit_q, stand_q} <= 3'b000;
            p_cnt <= '0; d_cnt <= '0;
            p_raw <= '0; d_raw <= '0;
            p_ace <= 1'b0; d_ace <= 1'b0;
        end else begin
            {start_q, hit_q, stand_q} <= {start, hit_btn, stand_btn};
            if ((state == IDLE || state == RESULT) && start_rise) begin
                p_cnt <= '0; d_cnt <= '0;
                p_raw <= '0; d_raw <= '0;
                p_ace <= 1'b0; d_ace <= 1'b0;
            end else if (accept && to_player) begin
                p_cnt <= p_cnt + 4'd1;
                p_raw <= p_nxt_raw;
                p_ace <= p_ace | card_ace;
            end else if (accept && to_dealer) begin
                d_cnt <= d_cnt + 4'd1;
                d_raw <= d_raw + card_val;
                d_ace <= d_ace | card_ace;
            end
        end
    end

    always_comb begin
        deal_req     = to_player || to_dealer;
        player_turn  = (state == PLAYER_TURN);
        load_player  = '0;
        load_dealer  = '0;
        player_win   = 1'b0;
        dealer_win   = 1'b0;
        push         = 1'b0;
        player_total = (p_best > 7'd31) ? 5'd31 : p_best[4:0];
        dealer_total = (d_best > 7'd31) ? 5'd31 : d_best[4:0];
        if (accept && to_player && p_cnt < MAXC) load_player = 8'd1 << p_cnt[2:0];
        if (accept && to_dealer && d_cnt < MAXC) load_dealer = 8'd1 << d_cnt[2:0];
        if (state == RESULT) begin
            if (p_best > 7'd21)       dealer_win = 1'b1;
            else if (d_best > 7'd21)  player_win = 1'b1;
            else if (p_best > d_best) player_win = 1'b1;
            else if (d_best > p_best) dealer_win = 1'b1;
            else                      push       = 1'b1;
        end
    end

endmodule
